fwd_sel_ctrl: RTL and testbench
===============================

// Module: fwd_sel_ctrl
// PURPOSE
// - Produces the 2-bit select codes that steer the EX-stage ALU operand 4:1 muxes
//   (operand A, operand B) of the 5-stage MIPS32 pipeline.
// - Keeps its own shadow of the EX/MEM/WB destination info as a 3-entry shift pipe,
//   so the datapath needs no extra compare logic.
// - Detects load-use hazards and drives the stall and bubble controls.
// PARAMETERS
// - REG_AW   5   register-address width
// PORTS
// - clk           in   1       pipeline clock, rising edge
// - rst_n         in   1       asynchronous reset, active low
// - hold          in   1       global freeze (e.g. memory wait); all state holds
// - flush         in   1       branch/jump taken; ID instruction is squashed, not entered into EX
// - id_valid      in   1       ID stage holds a real instruction
// - id_rs         in   REG_AW  source register A of the ID instruction
// - id_rt         in   REG_AW  source register B of the ID instruction
// - id_uses_rs    in   1       ID instruction reads rs
// - id_uses_rt    in   1       ID instruction reads rt
// - id_reg_write  in   1       ID instruction writes a register
// - id_mem_read   in   1       ID instruction is a load
// - id_dest       in   REG_AW  destination register of the ID instruction
// - fwd_a_sel     out  2       operand-A mux select, valid during the EX cycle
// - fwd_b_sel     out  2       operand-B mux select, valid during the EX cycle
// - stall         out  1       load-use stall; freezes PC and IF/ID (combinational)
// - ex_bubble     out  1       ID/EX is loaded with a NOP this edge (combinational)
// BEHAVIOUR
// - Select encoding, matching the mux inputs:
//   - 00: ID/EX register-file value
//   - 01: EX/MEM ALU result
//   - 10: MEM/WB result
//   - 11: retired write-back value, held one cycle past WB
// - Shadow entries ex/mem/wb each hold {v, wr, ld, dst}.
// - Entry "producer" means v & wr & dst != 0.
// - stall = id_valid & (id_uses_rs & rs==ex.dst | id_uses_rt & rt==ex.dst) & ex producer & ex.ld
// - stall is forced to 0 when hold=1 or flush=1.
// - ex_bubble = ~hold & (stall | flush | ~id_valid).
// - Each edge with hold=0:
//   - wb <= mem; mem <= ex
//   - ex <= ex_bubble ? invalid : {1, id_reg_write, id_mem_read, id_dest}
//   - fwd_*_sel is registered for the instruction entering EX:
//     - 01 if the source matches the ex producer
//     - else 10 if it matches the mem producer
//     - else 11 if it matches the wb producer
//     - else 00
//     - nearest match wins
//   - If the source is unused or is r0, the select is 00.
//   - On ex_bubble, both selects register 00.
// - hold=1: every register keeps its value; stall=0; ex_bubble=0.
// - flush and stall in the same cycle: flush wins (bubble inserted, stall=0).
// - Latency: a select is visible 1 cycle after the decode cycle, i.e. in the consumer's EX cycle.
//   - A stall costs exactly 1 cycle; the next edge moves the load to MEM and the consumer gets 01?
//     No. The consumer enters EX when the load is in WB, so it gets 10.
// - Reset (rst_n=0, asynchronous):
//   - all shadow entries are invalid
//   - fwd_a_sel = fwd_b_sel = 00
//   - stall = 0; ex_bubble follows id_valid (NOP)
// - Reset deasserted mid-program: no forwarding from pre-reset instructions.
// - Width rule: dst/rs/rt compare on all REG_AW bits; no truncation.
// TESTING
// - add r3 then add r4,r3,r3 back-to-back -> fwd_a_sel=fwd_b_sel=01 in consumer EX; stall=0.
// - producer r5, one NOP, consumer rs=r5 -> fwd_a_sel=10.
//   - With two NOPs -> 11; with three -> 00.
// - lw r2 then add r6,r2,r7 -> stall=1 and ex_bubble=1 for exactly 1 cycle.
//   - Then fwd_a_sel=10, fwd_b_sel=00.
// - Producers r8 at distances 1 and 2 both writing r8 -> consumer gets 01 (nearest wins).
//   - Writes to r0 never forward (sel=00).
// - hold=1 for 3 cycles mid-sequence -> selects/stall frozen, pipe resumes unchanged.
//   - flush with pending load-use -> stall=0, bubble in EX.
// - Assert rst_n=0 asynchronously between edges -> selects drop to 00 immediately.
//   - First post-reset consumer of an r3 written pre-reset gets 00.

Source files
------------

// File: rtl/fwd_sel_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_sel_ctrl
//   Generates the EX-stage ALU operand forwarding selects for a 5-stage MIPS32
//   pipeline. It also detects load-use hazards and drives the stall/bubble
//   controls. A 3-entry shadow pipe (ex/mem/wb) mirrors the destination info of
//   in-flight instructions, so the datapath needs no compare logic of its own.
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   hold         in   global freeze; all state holds, no stall/bubble issued
//   flush        in   branch/jump taken; ID instruction squashed before EX
//   id_valid     in   ID stage holds a real instruction
//   id_rs/id_rt  in   source registers of the ID instruction
//   id_uses_rs   in   ID instruction reads rs
//   id_uses_rt   in   ID instruction reads rt
//   id_reg_write in   ID instruction writes a register
//   id_mem_read  in   ID instruction is a load
//   id_dest      in   destination register of the ID instruction
//   fwd_a_sel    out  operand-A mux select for the instruction now in EX
//   fwd_b_sel    out  operand-B mux select for the instruction now in EX
//   stall        out  load-use stall, freezes PC and IF/ID (combinational)
//   ex_bubble    out  ID/EX loads a NOP on this edge (combinational)
//
// Select encoding
//   00 register-file value, 01 EX/MEM ALU result, 10 MEM/WB result,
//   11 retired write-back value held one cycle past WB
// -----------------------------------------------------------------------------
module fwd_sel_ctrl #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_AW-1:0] id_dest,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic              ex_bubble
);

   typedef enum logic [1:0] {
      SEL_RF      = 2'b00,
      SEL_EXMEM   = 2'b01,
      SEL_MEMWB   = 2'b10,
      SEL_RETIRED = 2'b11
   } sel_t;

   typedef struct packed {
      logic              v;
      logic              wr;
      logic              ld;
      logic [REG_AW-1:0] dst;
   } shadow_t;

   shadow_t ex_q;
   shadow_t mem_q;
   shadow_t wb_q;
   shadow_t ex_d;

   sel_t a_q;
   sel_t b_q;
   sel_t a_next;
   sel_t b_next;

   logic ex_ld_hit;

   // An entry only produces a forwardable value if it is live, writes a
   // register and that register is not the hard-wired zero.
   function automatic logic is_producer(input shadow_t e);
      return e.v && e.wr && (e.dst != '0);
   endfunction

   // The shadow entries are sampled one edge before the consumer reaches EX,
   // so each entry is one stage further along by the time the select is used:
   // ex -> EX/MEM, mem -> MEM/WB, wb -> retired register. Nearest wins.
   function automatic sel_t pick_src(
      input logic              used,
      input logic [REG_AW-1:0] src,
      input shadow_t           ex_e,
      input shadow_t           mem_e,
      input shadow_t           wb_e
   );
      sel_t s;
      s = SEL_RF;
      if (used && (src != '0)) begin
         if (is_producer(ex_e) && (src == ex_e.dst)) begin
            s = SEL_EXMEM;
         end else if (is_producer(mem_e) && (src == mem_e.dst)) begin
            s = SEL_MEMWB;
         end else if (is_producer(wb_e) && (src == wb_e.dst)) begin
            s = SEL_RETIRED;
         end
      end
      return s;
   endfunction

   // Load-use hazard: a load in EX whose result is needed by the ID
   // instruction cannot be forwarded in time. Freeze and flush both mask it;
   // a flushed consumer never reaches EX, so there is nothing to wait for.
   always_comb begin
      ex_ld_hit = 1'b0;
      if (is_producer(ex_q) && ex_q.ld) begin
         ex_ld_hit = (id_uses_rs && (id_rs == ex_q.dst)) ||
                     (id_uses_rt && (id_rt == ex_q.dst));
      end
   end

   always_comb begin
      stall     = id_valid && ex_ld_hit && !hold && !flush;
      ex_bubble = !hold && (stall || flush || !id_valid);
   end

   always_comb begin
      ex_d   = '0;
      a_next = SEL_RF;
      b_next = SEL_RF;
      if (!ex_bubble) begin
         ex_d.v   = 1'b1;
         ex_d.wr  = id_reg_write;
         ex_d.ld  = id_mem_read;
         ex_d.dst = id_dest;
         a_next   = pick_src(id_uses_rs, id_rs, ex_q, mem_q, wb_q);
         b_next   = pick_src(id_uses_rt, id_rt, ex_q, mem_q, wb_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         a_q   <= SEL_RF;
         b_q   <= SEL_RF;
      end else if (!hold) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
         a_q   <= a_next;
         b_q   <= b_next;
      end
   end

   assign fwd_a_sel = a_q;
   assign fwd_b_sel = b_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_sel_ctrl
//   Self-checking bench for fwd_sel_ctrl. The reference model keeps the last
//   three instructions that entered EX, indexed by distance (1 = most recent).
//   A consumer's select is simply the distance of its nearest matching
//   producer (1..3), or 0 when there is none.
// -----------------------------------------------------------------------------
module tb_fwd_sel_ctrl;

   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst_n;
   logic          hold;
   logic          flush;
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_uses_rs;
   logic          id_uses_rt;
   logic          id_reg_write;
   logic          id_mem_read;
   logic [AW-1:0] id_dest;
   logic [1:0]    fwd_a_sel;
   logic [1:0]    fwd_b_sel;
   logic          stall;
   logic          ex_bubble;

   int checks = 0;
   int errors = 0;

   // Model: in-flight instructions by distance, plus registered selects.
   logic          m_v   [1:3];
   logic          m_wr  [1:3];
   logic          m_ld  [1:3];
   logic [AW-1:0] m_dst [1:3];
   logic [1:0]    exp_a;
   logic [1:0]    exp_b;

   fwd_sel_ctrl #(.REG_AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hold         (hold),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .id_dest      (id_dest),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .ex_bubble    (ex_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_clear();
      for (int d = 1; d <= 3; d++) begin
         m_v[d] = 1'b0; m_wr[d] = 1'b0; m_ld[d] = 1'b0; m_dst[d] = '0;
      end
      exp_a = 2'b00;
      exp_b = 2'b00;
   endtask

   function automatic logic [1:0] model_sel(input logic used, input logic [AW-1:0] src);
      logic [1:0] s;
      s = 2'b00;
      if (used && src != 0) begin
         // oldest first so the nearest producer overwrites
         for (int d = 3; d >= 1; d--)
            if (m_v[d] && m_wr[d] && m_dst[d] == src) s = 2'(d);
      end
      return s;
   endfunction

   function automatic logic model_stall();
      logic need;
      need = (id_uses_rs && id_rs == m_dst[1]) || (id_uses_rt && id_rt == m_dst[1]);
      return !hold && !flush && id_valid && m_v[1] && m_wr[1] && m_ld[1] &&
             (m_dst[1] != 0) && need;
   endfunction

   function automatic logic model_bubble();
      return !hold && (model_stall() || flush || !id_valid);
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input logic wr, input logic ld, input int dst);
      id_valid     = v;
      id_rs        = AW'(rs);
      id_rt        = AW'(rt);
      id_uses_rs   = urs;
      id_uses_rt   = urt;
      id_reg_write = wr;
      id_mem_read  = ld;
      id_dest      = AW'(dst);
   endtask

   task automatic nop();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // Advance one clock edge, updating the model with the pre-edge inputs.
   task automatic tick();
      logic          b, nv, nwr, nld;
      logic [AW-1:0] ndst;
      logic [1:0]    na, nb;
      logic          upd;
      upd  = rst_n && !hold;
      b    = model_bubble();
      na   = b ? 2'b00 : model_sel(id_uses_rs, id_rs);
      nb   = b ? 2'b00 : model_sel(id_uses_rt, id_rt);
      nv   = !b;
      nwr  = b ? 1'b0 : id_reg_write;
      nld  = b ? 1'b0 : id_mem_read;
      ndst = b ? '0 : id_dest;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else if (upd) begin
         for (int d = 3; d >= 2; d--) begin
            m_v[d] = m_v[d-1]; m_wr[d] = m_wr[d-1]; m_ld[d] = m_ld[d-1]; m_dst[d] = m_dst[d-1];
         end
         m_v[1] = nv; m_wr[1] = nwr; m_ld[1] = nld; m_dst[1] = ndst;
         exp_a = na;
         exp_b = nb;
      end
      #1;
   endtask

   task automatic clear_pipe();
      hold = 1'b0; flush = 1'b0;
      nop(); tick(); tick(); tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      nop();
      model_clear();
      @(posedge clk); #1;
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 3);
      #1;
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL reset_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
      end
      checks++;
      if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
         errors++; $display("FAIL reset_valid: stall=%b bubble=%b expected 0 0", stall, ex_bubble);
      end
      nop(); #1;
      checks++;
      if (ex_bubble !== 1'b1 || stall !== 1'b0) begin
         errors++; $display("FAIL reset_nop: stall=%b bubble=%b expected 0 1", stall, ex_bubble);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      clear_pipe();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 3);   // add r3,r1,r2
      tick();
      drive(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 4);   // add r4,r3,r3
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL b2b_stall: stall=%b expected 0", stall);
      end
      tick();
      checks++;
      if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
         errors++; $display("FAIL b2b_sel: a=%b b=%b expected 01 01", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_distance();
      logic [1:0] want;
      for (int k = 0; k <= 3; k++) begin
         clear_pipe();
         drive(1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 5);
         tick();
         for (int n = 0; n < k; n++) begin nop(); tick(); end
         drive(1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
         tick();
         want = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
         checks++;
         if (fwd_a_sel !== want || fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL distance_%0d: a=%b b=%b expected %b 00", k, fwd_a_sel, fwd_b_sel, want);
         end
      end
   endtask

   task automatic test_load_use();
      clear_pipe();
      drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 2);   // lw r2
      tick();
      drive(1'b1, 2, 7, 1'b1, 1'b1, 1'b1, 1'b0, 6);   // add r6,r2,r7
      #1;
      checks++;
      if (stall !== 1'b1 || ex_bubble !== 1'b1) begin
         errors++; $display("FAIL lu_stall: stall=%b bubble=%b expected 1 1", stall, ex_bubble);
      end
      tick();
      checks++;
      if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
         errors++; $display("FAIL lu_release: stall=%b bubble=%b expected 0 0", stall, ex_bubble);
      end
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL lu_bubble_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
      end
      tick();
      checks++;
      if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL lu_consumer: a=%b b=%b expected 10 00", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_nearest_and_r0();
      clear_pipe();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 8);   // lw r8 (distance 2)
      tick();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 8);   // add r8 (distance 1)
      tick();
      drive(1'b1, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // rt unused
      tick();
      checks++;
      if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL nearest: a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
      end
      clear_pipe();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 0);   // write to r0
      tick();
      drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 9);
      tick();
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL r0_no_fwd: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_hold();
      clear_pipe();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 9);   // producer r9
      tick();
      drive(1'b1, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // consumer, no write
      tick();
      drive(1'b1, 9, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00 || stall !== 1'b0 || ex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL hold_frozen_%0d: a=%b b=%b stall=%b bubble=%b expected 01 00 0 0",
                     i, fwd_a_sel, fwd_b_sel, stall, ex_bubble);
         end
         tick();
      end
      hold = 1'b0;
      tick();
      checks++;
      if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
         errors++; $display("FAIL hold_resume: a=%b b=%b expected 10 10", fwd_a_sel, fwd_b_sel);
      end
      drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 10);  // lw r10
      tick();
      drive(1'b1, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      hold = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
         errors++; $display("FAIL hold_masks_stall: stall=%b bubble=%b expected 0 0", stall, ex_bubble);
      end
      tick();
      hold = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || ex_bubble !== 1'b1) begin
         errors++; $display("FAIL hold_then_stall: stall=%b bubble=%b expected 1 1", stall, ex_bubble);
      end
      tick();
   endtask

   task automatic test_flush();
      clear_pipe();
      drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 11);  // lw r11
      tick();
      drive(1'b1, 11, 0, 1'b1, 1'b0, 1'b1, 1'b0, 12);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || ex_bubble !== 1'b1) begin
         errors++; $display("FAIL flush_wins: stall=%b bubble=%b expected 0 1", stall, ex_bubble);
      end
      tick();
      flush = 1'b0;
      checks++;
      if (fwd_a_sel !== 2'b00) begin
         errors++; $display("FAIL flush_bubble_sel: a=%b expected 00", fwd_a_sel);
      end
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL flush_no_stall_after: stall=%b expected 0", stall);
      end
      tick();
      checks++;
      if (fwd_a_sel !== 2'b10) begin
         errors++; $display("FAIL flush_refetch_sel: a=%b expected 10", fwd_a_sel);
      end
   endtask

   task automatic test_async_reset();
      clear_pipe();
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 3);
      tick();
      drive(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 4);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL async_reset_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
      end
      model_clear();
      #1;
      rst_n = 1'b1;
      drive(1'b1, 3, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
         errors++; $display("FAIL post_reset_no_fwd: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(3, 0) != 0, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
               1'($urandom), 1'($urandom), $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
               int'($urandom_range(7, 0)));
         hold  = ($urandom_range(7, 0) == 0);
         flush = ($urandom_range(7, 0) == 0);
         #1;
         checks++;
         if (stall !== model_stall() || ex_bubble !== model_bubble()) begin
            errors++;
            $display("FAIL rand_ctl_%0d: stall=%b bubble=%b expected %b %b",
                     i, stall, ex_bubble, model_stall(), model_bubble());
         end
         if ($urandom_range(63, 0) == 0) begin
            rst_n = 1'b0;
            #1;
            model_clear();
            rst_n = 1'b1;
         end
         tick();
         checks++;
         if (fwd_a_sel !== exp_a || fwd_b_sel !== exp_b) begin
            errors++;
            $display("FAIL rand_sel_%0d: a=%b b=%b expected %b %b",
                     i, fwd_a_sel, fwd_b_sel, exp_a, exp_b);
         end
      end
      hold = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      nop();
      test_reset();
      test_back_to_back();
      test_distance();
      test_load_use();
      test_nearest_and_r0();
      test_hold();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
